// File: rtl/console_pkg.sv
// Console FSM states, seven-segment constants and the hex digit decoder.
package console_pkg;

    typedef enum logic [1:0] {S_A, S_B, S_OP, S_SHOW} console_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and ALU opcode encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLT = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7
    } aluop_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low push button, filters bounce and emits a
// single-cycle pulse when the filtered key goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1, sync2, stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            pressed <= 1'b0;
            // Any return to the filtered level restarts the stability window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable  <= sync2;
                cnt     <= '0;
                pressed <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_console.sv
// Board console for an external ALU: debounced keys drive an operand-entry
// FSM, results are captured in S_SHOW and shown on a paged hex display.
module alu_console
    import console_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int DIGITS          = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [3:0]              KEY,
    input  logic [17:0]             SW,
    output logic [DIGITS-1:0][6:0]  HEX,
    output logic [7:0]              LEDR,
    output logic [DATA_W-1:0]       alu_porta,
    output logic [DATA_W-1:0]       alu_portb,
    output aluop_t                  alu_op,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    input  logic                    alu_ovf
);

    localparam int NSLICE  = DATA_W / 16;
    localparam int SEL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int PAGES   = (DATA_W + 4*DIGITS - 1) / (4*DIGITS);
    localparam int PAGE_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int NIBBLES = DIGITS * PAGES;

    logic [3:0] key_press;
    logic       do_clear, do_back, do_adv, do_page;

    console_state_t state, state_nxt;
    logic           ld_a, ld_b, ld_op, capture;

    logic [DATA_W-1:0] a, b, res, target, entry;
    aluop_t            op;
    logic [2:0]        flags;
    logic [PAGE_W-1:0] page;
    int                slice;

    logic [DATA_W-1:0]    shown;
    logic [4*NIBBLES-1:0] shown_pad;
    logic [DIGITS-1:0][6:0] hex_nxt;
    logic [7:0]           ledr_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .key_n    (KEY[i]),
            .pressed  (key_press[i])
        );
    end

    assign do_clear = key_press[3];
    assign do_back  = key_press[1] & ~do_clear;
    assign do_adv   = key_press[0] & ~do_clear & ~do_back;
    assign do_page  = key_press[2];

    always_ff @(posedge CLOCK_50) begin
        if (RESET || do_clear) state <= S_A;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (do_back) begin
            case (state)
                S_B:     state_nxt = S_A;
                S_OP:    state_nxt = S_B;
                S_SHOW:  state_nxt = S_OP;
                default: state_nxt = S_A;
            endcase
        end else if (do_adv) begin
            case (state)
                S_A:     state_nxt = S_B;
                S_B:     state_nxt = S_OP;
                S_OP:    state_nxt = S_SHOW;
                default: state_nxt = S_A;
            endcase
        end
    end

    always_comb begin
        ld_a    = do_adv && (state == S_A);
        ld_b    = do_adv && (state == S_B);
        ld_op   = do_adv && (state == S_OP);
        capture = (state == S_SHOW);
    end

    // Entry value: sign-extended switches, or a 16-bit slice patched into the target.
    always_comb begin
        target = (state == S_B) ? b : a;
        slice  = int'(SW[16 +: SEL_W]) % NSLICE;
        if (SW[17]) begin
            entry = target;
            for (int k = 0; k < NSLICE; k++)
                if (k == slice) entry[16*k +: 16] = SW[15:0];
        end else begin
            entry       = {DATA_W{SW[16]}};
            entry[15:0] = SW[15:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET || do_clear) begin
            a     <= '0;
            b     <= '0;
            res   <= '0;
            op    <= aluop_t'(0);
            flags <= '0;
            page  <= '0;
        end else begin
            if (ld_a)    a  <= entry;
            if (ld_b)    b  <= entry;
            if (ld_op)   op <= aluop_t'(SW[3:0]);
            if (capture) begin
                res   <= alu_out;
                flags <= {alu_ovf, alu_neg, alu_zero};
            end
            if (do_page) page <= (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;
        end
    end

    assign alu_porta = a;
    assign alu_portb = b;
    assign alu_op    = op;

    always_comb begin
        shown                    = (state == S_SHOW) ? res : entry;
        shown_pad                = '0;
        shown_pad[DATA_W-1:0]    = shown;
        for (int d = 0; d < DIGITS; d++) begin
            int n;
            n = int'(page) * DIGITS + d;
            if (state == S_OP)
                hex_nxt[d] = (d == 0) ? hex7seg(op) : SEG_DASH;
            else if (n * 4 >= DATA_W)
                hex_nxt[d] = SEG_BLANK;
            else
                hex_nxt[d] = hex7seg(shown_pad[4*n +: 4]);
        end
        ledr_nxt[7:4] = 4'b0001 << state;
        ledr_nxt[3]   = (page != '0);
        ledr_nxt[2:0] = (state == S_SHOW) ? flags : 3'b000;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET || do_clear) begin
            HEX  <= {DIGITS{SEG_BLANK}};
            LEDR <= '0;
        end else begin
            HEX  <= hex_nxt;
            LEDR <= ledr_nxt;
        end
    end

endmodule

// File: tb/tb_alu_console.sv
// Randomised bench: two console builds (8 and 4 digits) on a shared board,
// each driving an ADD-style ALU, compared against an action-level model.
module tb_alu_console;
    import cpu_types_pkg::*;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key = 4'hF;
    logic [17:0] sw  = '0;

    logic [7:0][6:0] hex8;
    logic [3:0][6:0] hex4;
    logic [7:0]      ledr8, ledr4;
    logic [31:0]     pa8, pb8, out8, pa4, pb4, out4;
    aluop_t          op8, op4;
    logic            z8, n8, v8, z4, n4, v4;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0=S_A 1=S_B 2=S_OP 3=S_SHOW
    int          m_st  = 0;
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic [3:0]  m_op  = '0;
    int          m_pg4 = 0;

    always #5 clk = ~clk;

    // External ALU: ADD for the ADD code, XOR for anything else.
    function automatic logic [34:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        logic [31:0] r;
        logic        ov;
        if (o == 4'(ALU_ADD)) begin
            r  = x + y;
            ov = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            r  = x ^ y;
            ov = 1'b0;
        end
        return {ov, r[31], (r == 32'd0), r};
    endfunction

    assign {v8, n8, z8, out8} = alu_f(pa8, pb8, op8);
    assign {v4, n4, z4, out4} = alu_f(pa4, pb4, op4);

    alu_console #(.DATA_W(32), .DIGITS(8), .DEBOUNCE_CYCLES(DC)) dut8 (
        .CLOCK_50(clk), .RESET(rst), .KEY(key), .SW(sw), .HEX(hex8), .LEDR(ledr8),
        .alu_porta(pa8), .alu_portb(pb8), .alu_op(op8), .alu_out(out8),
        .alu_zero(z8), .alu_neg(n8), .alu_ovf(v8)
    );

    alu_console #(.DATA_W(32), .DIGITS(4), .DEBOUNCE_CYCLES(DC)) dut4 (
        .CLOCK_50(clk), .RESET(rst), .KEY(key), .SW(sw), .HEX(hex4), .LEDR(ledr4),
        .alu_porta(pa4), .alu_portb(pb4), .alu_op(op4), .alu_out(out4),
        .alu_zero(z4), .alu_neg(n4), .alu_ovf(v4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] entry_v(input logic [17:0] s, input logic [31:0] tgt);
        logic [31:0] v;
        if (s[17]) begin
            v = tgt;
            if (s[16]) v[31:16] = s[15:0];
            else       v[15:0]  = s[15:0];
        end else begin
            v = {{16{s[16]}}, s[15:0]};
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_hex(input int digits, input int pg, input int st,
                                            input logic [31:0] word, input logic [3:0] o);
        logic [63:0] r;
        logic [31:0] sh;
        r = '0;
        for (int d = 0; d < digits; d++) begin
            int n;
            n  = pg * digits + d;
            sh = word >> (4 * (n % 8));
            if (st == 2)        r[7*d +: 7] = (d == 0) ? seg_of(o) : 7'b0111111;
            else if (n * 4 >= 32) r[7*d +: 7] = 7'h7F;
            else                r[7*d +: 7] = seg_of(sh[3:0]);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_ledr(input int st, input int pg, input logic [2:0] fl);
        logic [7:0] l;
        l      = '0;
        l[4+st] = 1'b1;
        l[3]   = (pg != 0);
        l[2:0] = (st == 3) ? fl : 3'b000;
        return l;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] v, word;
        logic [34:0] alu;
        v    = entry_v(sw, (m_st == 1) ? m_b : m_a);
        alu  = alu_f(m_a, m_b, m_op);
        word = (m_st == 3) ? alu[31:0] : v;
        chk({tag, ".hex8"},  64'(hex8),  exp_hex(8, 0, m_st, word, m_op));
        chk({tag, ".hex4"},  64'(hex4),  exp_hex(4, m_pg4, m_st, word, m_op));
        chk({tag, ".ledr8"}, 64'(ledr8), 64'(exp_ledr(m_st, 0, alu[34:32])));
        chk({tag, ".ledr4"}, 64'(ledr4), 64'(exp_ledr(m_st, m_pg4, alu[34:32])));
        chk({tag, ".porta"}, 64'(pa8),   64'(m_a));
        chk({tag, ".portb"}, 64'(pb8),   64'(m_b));
        chk({tag, ".op"},    64'(op8),   64'(m_op));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_key(input logic [3:0] mask);
        if (mask[3]) begin
            m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_pg4 = 0;
        end else begin
            if (mask[1]) begin
                if (m_st > 0) m_st--;
            end else if (mask[0]) begin
                case (m_st)
                    0: begin m_a = entry_v(sw, m_a); m_st = 1; end
                    1: begin m_b = entry_v(sw, m_b); m_st = 2; end
                    2: begin m_op = sw[3:0];         m_st = 3; end
                    default: m_st = 0;
                endcase
            end
            if (mask[2]) m_pg4 = (m_pg4 + 1) % 2;
        end
    endtask

    task automatic do_key(input logic [3:0] mask);
        @(negedge clk);
        key = ~mask;
        tick(DC + 8);
        key = 4'hF;
        tick(DC + 8);
        model_key(mask);
    endtask

    initial begin
        tick(3);
        chk("rst.hex8",  64'(hex8),  {8'h0, {8{7'h7F}}});
        chk("rst.hex4",  64'(hex4),  {36'h0, {4{7'h7F}}});
        chk("rst.ledr8", 64'(ledr8), 64'h0);
        chk("rst.porta", 64'(pa8),   64'h0);
        rst = 1'b0;
        tick(3);
        check_all("idle");

        // 5 + 3 with ADD
        sw = 18'h00005; do_key(4'h1);
        sw = 18'h00003; do_key(4'h1);
        sw = 18'(ALU_ADD); do_key(4'h1);
        check_all("t1");
        chk("t1.res", 64'(hex8), exp_hex(8, 0, 3, 32'h8, 4'h0));
        chk("t1.flags", 64'(ledr8[2:0]), 64'h0);
        do_key(4'h1);

        // -1 + 1 -> zero; then 0x7FFFFFFF + 1 -> neg and ovf
        sw = 18'h1FFFF; do_key(4'h1);
        sw = 18'h00001; do_key(4'h1);
        sw = 18'(ALU_ADD); do_key(4'h1);
        check_all("t2a");
        chk("t2a.zero", 64'(ledr8[0]), 64'h1);
        do_key(4'h1);
        sw = 18'h2FFFF; do_key(4'h1);
        do_key(4'h2);
        sw = 18'h37FFF; do_key(4'h1);
        chk("t2.porta", 64'(pa8), 64'h7FFFFFFF);
        sw = 18'h00001; do_key(4'h1);
        sw = 18'(ALU_ADD); do_key(4'h1);
        check_all("t2b");
        chk("t2b.negovf", 64'(ledr8[2:1]), 64'h3);
        do_key(4'h1);

        // Bounce shorter than the window gives nothing; a long hold gives one advance
        sw = 18'h01234;
        for (int i = 0; i < 5; i++) begin
            key[0] = 1'b0; tick(2);
            key[0] = 1'b1; tick(2);
        end
        tick(DC + 8);
        check_all("t3.bounce");
        key[0] = 1'b0;
        tick(40);
        model_key(4'h1);
        check_all("t3.held");
        key[0] = 1'b1;
        tick(DC + 8);
        check_all("t3.release");
        do_key(4'h1);
        check_all("t3.second");

        // Back and advance in the same cycle: back wins
        do_key(4'h2);
        sw = 18'h0ABCD;
        do_key(4'h3);
        check_all("t4.backwins");
        sw = 18'h00042; do_key(4'h1);
        do_key(4'h1);
        sw = 18'(ALU_ADD); do_key(4'h1);
        do_key(4'h8);
        check_all("t4.clear");
        chk("t4.clr_a", 64'(pa8), 64'h0);

        // 0000BEEF + DEAD0000 paged on the 4-digit build
        sw = 18'h0BEEF; do_key(4'h1);
        sw = 18'h3DEAD; do_key(4'h1);
        sw = 18'(ALU_ADD); do_key(4'h1);
        check_all("t5.p0");
        chk("t5.beef", 64'(hex4), exp_hex(4, 0, 0, 32'hBEEF, 4'h0));
        do_key(4'h4);
        check_all("t5.p1");
        chk("t5.page_led", 64'(ledr4[3]), 64'h1);
        do_key(4'h4);
        check_all("t5.wrap");

        // Reset mid-debounce while in S_OP
        do_key(4'h2);
        check_all("t6.op");
        @(negedge clk);
        key[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        key = 4'hF;
        tick(1);
        chk("t6.hex8", 64'(hex8), {8'h0, {8{7'h7F}}});
        chk("t6.ledr8", 64'(ledr8), 64'h0);
        rst = 1'b0;
        model_key(4'h8);
        tick(DC + 10);
        check_all("t6.after");

        // Random walk through the console
        for (int it = 0; it < 40; it++) begin
            int r;
            sw = 18'($urandom);
            r  = $urandom_range(0, 99);
            if (r < 55)      do_key(4'h1);
            else if (r < 70) do_key(4'h2);
            else if (r < 85) do_key(4'h4);
            else if (r < 92) do_key(4'h8);
            else             tick(3);
            check_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
